// File: rtl/button_conditioner_if.sv
// Button bus between the pins/bench and button_conditioner.
// Strobe semantics: butt_pulse is a single-cycle strobe with no valid/ready
// handshake. The consumer must take it on the cycle it is high.
interface button_conditioner_if;
   logic [3:0] butt_raw;
   logic [3:0] butt_level;
   logic [3:0] butt_pulse;
   logic       any_pressed;
   logic [7:0] dbg_state;   // per-button repeat FSM state, 2 bits each, button i at [2i+1:2i]

   modport master (
      output butt_raw,
      input  butt_level, butt_pulse, any_pressed, dbg_state
   );

   modport slave (
      input  butt_raw,
      output butt_level, butt_pulse, any_pressed, dbg_state
   );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and pulse-shapes the four player buttons {D,R,T,L}.
// Selected buttons also auto-repeat while they are held.
module button_conditioner #(
   parameter int       DEBOUNCE_CYCLES = 250000,
   parameter int       REPEAT_DELAY    = 5000000,
   parameter int       REPEAT_RATE     = 1500000,
   parameter bit [3:0] REPEAT_MASK     = 4'b1101,
   parameter bit       ACTIVE_LOW      = 1'b0
) (
   input logic                 clk_25_175,
   input logic                 reset,
   button_conditioner_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      HELD   = 2'd3
   } rep_state_t;

   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int RW   = $clog2(RMAX);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

   logic [3:0] s1;
   logic [3:0] s;
   logic [3:0] level_nxt;
   logic       any_q;

   always_ff @(posedge clk_25_175 or posedge reset) begin
      if (reset) begin
         s1    <= '0;
         s     <= '0;
         any_q <= 1'b0;
      end else begin
         s1    <= bus.butt_raw ^ {4{ACTIVE_LOW}};
         s     <= s1;
         any_q <= |level_nxt;
      end
   end

   assign bus.any_pressed = any_q;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      logic [DW-1:0] dcnt;
      logic          level_q;
      logic          dcnt_done;
      logic          rise;
      logic          fall;
      rep_state_t    st;
      rep_state_t    st_nxt;
      logic [RW-1:0] rcnt;
      logic [RW-1:0] rcnt_nxt;
      logic          pulse_q;
      logic          pulse_n;

      // The level flips on the same edge the counter hits its terminal value.
      assign dcnt_done    = (s[i] != level_q) && (dcnt == DB_LAST);
      assign rise         = dcnt_done &&  s[i];
      assign fall         = dcnt_done && !s[i];
      assign level_nxt[i] = dcnt_done ? s[i] : level_q;

      always_ff @(posedge clk_25_175 or posedge reset) begin
         if (reset) begin
            dcnt    <= '0;
            level_q <= 1'b0;
         end else begin
            level_q <= level_nxt[i];
            if (s[i] == level_q || dcnt_done) dcnt <= '0;
            else                              dcnt <= dcnt + DW'(1);
         end
      end

      always_ff @(posedge clk_25_175 or posedge reset) begin
         if (reset) begin
            st      <= IDLE;
            rcnt    <= '0;
            pulse_q <= 1'b0;
         end else begin
            st      <= st_nxt;
            rcnt    <= rcnt_nxt;
            pulse_q <= pulse_n;
         end
      end

      // A release wins over any terminal count falling on the same cycle.
      always_comb begin
         st_nxt   = st;
         rcnt_nxt = rcnt;
         pulse_n  = 1'b0;
         if (fall) begin
            st_nxt   = IDLE;
            rcnt_nxt = '0;
         end else begin
            case (st)
               IDLE: begin
                  if (rise) begin
                     pulse_n  = 1'b1;
                     rcnt_nxt = '0;
                     st_nxt   = REPEAT_MASK[i] ? DELAY : HELD;
                  end
               end
               DELAY: begin
                  if (rcnt == RD_LAST) begin
                     pulse_n  = 1'b1;
                     rcnt_nxt = '0;
                     st_nxt   = REPEAT;
                  end else begin
                     rcnt_nxt = rcnt + RW'(1);
                  end
               end
               REPEAT: begin
                  if (rcnt == RR_LAST) begin
                     pulse_n  = 1'b1;
                     rcnt_nxt = '0;
                  end else begin
                     rcnt_nxt = rcnt + RW'(1);
                  end
               end
               HELD:    st_nxt = HELD;
               default: st_nxt = IDLE;
            endcase
         end
      end

      assign bus.butt_level[i]       = level_q;
      assign bus.butt_pulse[i]       = pulse_q;
      assign bus.dbg_state[2*i +: 2] = st;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing.
module tb_button_conditioner;

  logic clk_25_175 = 1'b0;
  logic reset      = 1'b1;

  always #5 clk_25_175 = ~clk_25_175;

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(3),
    .REPEAT_MASK(4'b1101),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk_25_175(clk_25_175),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic       any;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_25_175);
    #1;
    cyc++;
    for (int b = 0; b < 4; b++)
      if (bus.butt_pulse[b] === 1'b1) got_q.push_back(32'(cyc * 4 + b));
  endtask

  task automatic wait_level(input int b, input logic v, input int budget, output int n);
    n = 0;
    while (bus.butt_level[b] !== v && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic compare_pulses(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic add(input logic [3:0] raw, input int n, input logic [3:0] lvl,
                     input logic [3:0] pls, input logic any);
    vec_t v;
    v.raw = raw; v.lvl = lvl; v.pls = pls; v.any = any;
    repeat (n) vecs.push_back(v);
  endtask

  initial begin
    int n;
    int r;
    int c0;
    int offs[8];
    offs = '{0, 10, 13, 16, 19, 22, 25, 28};

    // L clean press (8 cycles) and release
    add(4'b0001, 5, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 1, 4'b0001, 4'b0001, 1'b1);
    add(4'b0001, 2, 4'b0001, 4'b0000, 1'b1);
    add(4'b0000, 5, 4'b0001, 4'b0000, 1'b1);
    add(4'b0000, 2, 4'b0000, 4'b0000, 1'b0);
    // L bouncing 1,0,1,0 every 2 cycles, then held
    add(4'b0001, 2, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 2, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 2, 4'b0000, 4'b0000, 1'b0);
    add(4'b0000, 2, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 5, 4'b0000, 4'b0000, 1'b0);
    add(4'b0001, 1, 4'b0001, 4'b0001, 1'b1);
    add(4'b0001, 1, 4'b0001, 4'b0000, 1'b1);
    add(4'b0000, 5, 4'b0001, 4'b0000, 1'b1);
    add(4'b0000, 3, 4'b0000, 4'b0000, 1'b0);

    // Reset state
    bus.butt_raw = 4'b0000;
    repeat (3) step();
    check("reset_hold_outputs", {bus.butt_level, bus.butt_pulse, bus.any_pressed, bus.dbg_state}, 32'd0);
    @(negedge clk_25_175);
    reset = 1'b0;
    step();
    check("reset_release_outputs", {bus.butt_level, bus.butt_pulse, bus.any_pressed, bus.dbg_state}, 32'd0);

    // Table-driven L sequences
    for (int i = 0; i < vecs.size(); i++) begin
      bus.butt_raw = vecs[i].raw;
      step();
      check($sformatf("vec%0d", i), {bus.butt_level, bus.butt_pulse, bus.any_pressed},
            {vecs[i].lvl, vecs[i].pls, vecs[i].any});
    end
    got_q.delete();

    // R held: auto-repeat cadence, release ends repeats
    bus.butt_raw = 4'b0100;
    wait_level(2, 1'b1, 20, n);
    check("r_press_latency", n, 6);
    r = cyc;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'((r + offs[i]) * 4 + 2));
    repeat (24) step();
    bus.butt_raw = 4'b0000;
    wait_level(2, 1'b0, 20, n);
    check("r_fall_cycle", 32'(cyc - r), 32'd30);
    repeat (10) step();
    compare_pulses("r_pulses");

    // T held: single pulse, HELD, second press gives one more
    bus.butt_raw = 4'b0010;
    wait_level(1, 1'b1, 20, n);
    check("t_press_latency", n, 6);
    exp_q.push_back(32'(cyc * 4 + 1));
    repeat (40) step();
    check("t_state_held", bus.dbg_state[3:2], 2'd3);
    bus.butt_raw = 4'b0000;
    wait_level(1, 1'b0, 20, n);
    check("t_release_latency", n, 6);
    check("t_state_idle", bus.dbg_state[3:2], 2'd0);
    repeat (3) step();
    bus.butt_raw = 4'b0010;
    wait_level(1, 1'b1, 20, n);
    exp_q.push_back(32'(cyc * 4 + 1));
    repeat (15) step();
    bus.butt_raw = 4'b0000;
    wait_level(1, 1'b0, 20, n);
    repeat (3) step();
    compare_pulses("t_pulses");

    // L and D together; L released early, D keeps its cadence
    bus.butt_raw = 4'b1001;
    wait_level(0, 1'b1, 20, n);
    check("ld_press_latency", n, 6);
    check("ld_same_cycle_pulse", bus.butt_pulse, 4'b1001);
    r = cyc;
    bus.butt_raw = 4'b1000;
    exp_q.push_back(32'(r * 4 + 0));
    exp_q.push_back(32'(r * 4 + 3));
    for (int k = 10; k <= 19; k += 3) exp_q.push_back(32'((r + k) * 4 + 3));
    repeat (20) step();
    check("ld_levels_after_l_release", bus.butt_level, 4'b1000);
    check("d_state_repeat", bus.dbg_state[7:6], 2'd2);
    compare_pulses("ld_pulses");

    // Asynchronous reset mid-REPEAT on D, D kept held
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_outputs", {bus.butt_level, bus.butt_pulse, bus.any_pressed, bus.dbg_state}, 32'd0);
    repeat (2) step();
    check("rst_held_outputs", {bus.butt_level, bus.butt_pulse, bus.any_pressed, bus.dbg_state}, 32'd0);
    got_q.delete();
    @(negedge clk_25_175);
    reset = 1'b0;
    c0 = cyc;
    exp_q.push_back(32'((c0 + 6) * 4 + 3));
    wait_level(3, 1'b1, 20, n);
    check("rst_redebounce_latency", n, 6);
    compare_pulses("rst_pulses");

    bus.butt_raw = 4'b0000;
    repeat (8) step();
    check("final_idle", {bus.butt_level, bus.any_pressed}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
